// File: rtl/axis_ddr3_traffic_gen.sv
// Write/read-back traffic generator and checker for the DDR3 test design, on byte-wide AXI-Stream.
// Define TRAFFIC_GEN_CAPTURE_EN to add first-failure capture outputs (fail_addr_o, fail_exp_o, fail_got_o).
module axis_ddr3_traffic_gen #(
    parameter int          BURST_WORDS  = 16,
    parameter int          BURSTS       = 4,
    parameter logic [26:0] BASE_ADDR    = 27'h0000000,
    parameter logic [31:0] PATTERN_SEED = 32'hA5A5_0001,
    parameter logic [15:0] TIMEOUT      = 16'd65535
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        fault_o,
    output logic [15:0] err_count_o,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tkeep,
    output logic        m_tlast,
    output logic [7:0]  m_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    input  logic        s_tkeep,
    input  logic        s_tlast,
    input  logic [7:0]  s_tdata
`ifdef TRAFFIC_GEN_CAPTURE_EN
    ,
    output logic [26:0] fail_addr_o,
    output logic [31:0] fail_exp_o,
    output logic [31:0] fail_got_o
`endif
);

    localparam int          FRAME_BYTES  = 4 * BURST_WORDS;
    localparam logic [10:0] LAST_BYTE    = 11'(FRAME_BYTES - 1);
    localparam logic [8:0]  LAST_BURST   = 9'(BURSTS - 1);
    localparam logic [7:0]  LEN_BYTE     = 8'(BURST_WORDS - 1);
    localparam logic [26:0] BURST_STRIDE = 27'(FRAME_BYTES);
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [15:0] TO_LAST      = TIMEOUT - 16'd1;

    typedef enum logic [2:0] {IDLE, WR_HDR, WR_DAT, RD_HDR, RD_DAT, DONE} state_t;

    state_t      state, state_next;
    logic [10:0] tx_cnt;
    logic [10:0] rx_cnt;
    logic [15:0] tcnt;
    logic [8:0]  burst;
    logic [26:0] addr;
    logic [31:0] lfsr;
    logic [23:0] word_buf;
    logic [7:0]  tx_byte;
    logic        tx_byte_last;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        lfsr_next = {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        sat_inc = (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic        start_run, tx_active, tx_load, tx_end, last_burst;
    logic        rx_hs, rx_last, word_done, word_bad, rx_fault, rx_timeout;
    logic [31:0] rx_word;

    assign start_run  = start_i && (state == IDLE || state == DONE);
    assign tx_active  = (state == WR_HDR) || (state == WR_DAT) || (state == RD_HDR);
    // Refill the output register whenever it is empty or draining, until the framing byte is loaded.
    assign tx_load    = tx_active && (!m_tvalid || m_tready) && !m_tlast;
    assign tx_end     = m_tvalid && m_tready && m_tlast;
    assign last_burst = (burst == LAST_BURST);
    assign rx_hs      = s_tvalid && s_tready;
    assign rx_last    = (rx_cnt == LAST_BYTE);
    assign word_done  = rx_hs && (rx_cnt[1:0] == 2'd3);
    assign rx_word    = {s_tdata, word_buf};
    assign word_bad   = word_done && (rx_word != lfsr);
    assign rx_fault   = rx_hs && (!s_tkeep || (s_tlast != rx_last));
    assign rx_timeout = (state == RD_DAT) && !rx_hs && (tcnt == TO_LAST);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        s_tready   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) state_next = WR_HDR;
            end
            WR_HDR: begin
                busy_o = 1'b1;
                if (tx_load && tx_cnt == 11'd5) state_next = WR_DAT;
            end
            WR_DAT: begin
                busy_o = 1'b1;
                if (tx_end) state_next = last_burst ? RD_HDR : WR_HDR;
            end
            RD_HDR: begin
                busy_o = 1'b1;
                if (tx_end) state_next = RD_DAT;
            end
            RD_DAT: begin
                busy_o   = 1'b1;
                s_tready = 1'b1;
                if (rx_fault || rx_timeout)  state_next = DONE;
                else if (rx_hs && rx_last)   state_next = last_burst ? DONE : RD_HDR;
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) state_next = WR_HDR;
            end
            default: state_next = IDLE;
        endcase
    end

    assign pass_o = done_o && (err_count_o == 16'd0) && !fault_o;

    // Next request byte: header fields for WR_HDR/RD_HDR, little-endian LFSR word in WR_DAT.
    always_comb begin
        tx_byte      = 8'h00;
        tx_byte_last = 1'b0;
        if (state == WR_DAT) begin
            case (tx_cnt[1:0])
                2'd0:    tx_byte = lfsr[7:0];
                2'd1:    tx_byte = lfsr[15:8];
                2'd2:    tx_byte = lfsr[23:16];
                default: tx_byte = lfsr[31:24];
            endcase
            tx_byte_last = (tx_cnt == LAST_BYTE);
        end else begin
            case (tx_cnt[2:0])
                3'd0:    tx_byte = (state == RD_HDR) ? 8'h80 : 8'hA0;
                3'd1:    tx_byte = LEN_BYTE;
                3'd2:    tx_byte = {5'b0, addr[26:24]};
                3'd3:    tx_byte = addr[23:16];
                3'd4:    tx_byte = addr[15:8];
                default: tx_byte = addr[7:0];
            endcase
            tx_byte_last = (state == RD_HDR) && (tx_cnt == 11'd5);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            m_tvalid    <= 1'b0;
            m_tkeep     <= 1'b0;
            m_tlast     <= 1'b0;
            m_tdata     <= 8'h00;
            tx_cnt      <= '0;
            rx_cnt      <= '0;
            tcnt        <= '0;
            burst       <= '0;
            addr        <= BASE_ADDR;
            lfsr        <= PATTERN_SEED;
            err_count_o <= '0;
            fault_o     <= 1'b0;
        end else begin
            if (tx_load) begin
                m_tvalid <= 1'b1;
                m_tkeep  <= 1'b1;
                m_tdata  <= tx_byte;
                m_tlast  <= tx_byte_last;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
                m_tkeep  <= 1'b0;
                m_tlast  <= 1'b0;
            end

            if (start_run) begin
                tx_cnt      <= '0;
                rx_cnt      <= '0;
                tcnt        <= '0;
                burst       <= '0;
                addr        <= BASE_ADDR;
                lfsr        <= PATTERN_SEED;
                err_count_o <= '0;
                fault_o     <= 1'b0;
            end

            if (tx_load) tx_cnt <= (state == WR_HDR && tx_cnt == 11'd5) ? 11'd0 : tx_cnt + 11'd1;
            else if (tx_end) tx_cnt <= '0;

            if (state == WR_DAT && tx_load && tx_cnt[1:0] == 2'd3) lfsr <= lfsr_next(lfsr);

            // End of the write phase re-arms address, index and pattern for the read-back pass.
            if (state == WR_DAT && tx_end) begin
                if (last_burst) begin
                    burst <= '0;
                    addr  <= BASE_ADDR;
                    lfsr  <= PATTERN_SEED;
                end else begin
                    burst <= burst + 9'd1;
                    addr  <= addr + BURST_STRIDE;
                end
            end

            if (state == RD_HDR && tx_end) begin
                rx_cnt <= '0;
                tcnt   <= '0;
            end

            if (state == RD_DAT) begin
                if (rx_hs) begin
                    tcnt   <= '0;
                    rx_cnt <= rx_last ? 11'd0 : rx_cnt + 11'd1;
                    if (word_done) lfsr <= lfsr_next(lfsr);
                    if (word_bad) err_count_o <= sat_inc(err_count_o);
                    if (rx_last) begin
                        burst <= burst + 9'd1;
                        addr  <= addr + BURST_STRIDE;
                    end
                end else begin
                    tcnt <= tcnt + 16'd1;
                end
                if (rx_fault || rx_timeout) fault_o <= 1'b1;
            end
        end
    end

    // Assembles the low three bytes of each response word; the fourth arrives live on s_tdata.
    always_ff @(posedge clock) begin
        if (rx_hs) begin
            case (rx_cnt[1:0])
                2'd0:    word_buf[7:0]   <= s_tdata;
                2'd1:    word_buf[15:8]  <= s_tdata;
                2'd2:    word_buf[23:16] <= s_tdata;
                default: word_buf        <= word_buf;
            endcase
        end
    end

`ifdef TRAFFIC_GEN_CAPTURE_EN
    always_ff @(posedge clock) begin
        if (reset || start_run) begin
            fail_addr_o <= '0;
            fail_exp_o  <= '0;
            fail_got_o  <= '0;
        end else if (word_bad && err_count_o == 16'd0) begin
            fail_addr_o <= addr + 27'(rx_cnt) - 27'd3;
            fail_exp_o  <= lfsr;
            fail_got_o  <= rx_word;
        end
    end
`else
    // Without capture only the mismatch count is reported.
`endif

endmodule

// File: tb/tb_axis_ddr3_traffic_gen.sv
// Bench for axis_ddr3_traffic_gen: loopback memory model on the stream ports, request-byte scoreboard.
// Also builds with TRAFFIC_GEN_CAPTURE_EN defined, adding the capture-port checks.
module tb_axis_ddr3_traffic_gen;

    localparam int          BW   = 4;
    localparam int          NB   = 2;
    localparam logic [15:0] TO   = 16'd40;
    localparam logic [31:0] SEED = 32'hA5A5_0001;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_i;
    logic        busy_o, done_o, pass_o, fault_o;
    logic [15:0] err_count_o;
    logic        m_tvalid, m_tready, m_tkeep, m_tlast;
    logic [7:0]  m_tdata;
    logic        s_tvalid, s_tready, s_tkeep, s_tlast;
    logic [7:0]  s_tdata;
`ifdef TRAFFIC_GEN_CAPTURE_EN
    logic [26:0] fail_addr_o;
    logic [31:0] fail_exp_o, fail_got_o;
`endif

    axis_ddr3_traffic_gen #(
        .BURST_WORDS(BW), .BURSTS(NB), .BASE_ADDR(27'h0), .PATTERN_SEED(SEED), .TIMEOUT(TO)
    ) dut (
        .clock(clock), .reset(reset), .start_i(start_i),
        .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .fault_o(fault_o),
        .err_count_o(err_count_o),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .m_tdata(m_tdata),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .s_tdata(s_tdata)
`ifdef TRAFFIC_GEN_CAPTURE_EN
        , .fail_addr_o(fail_addr_o), .fail_exp_o(fail_exp_o), .fail_got_o(fail_got_o)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {int addr; int n;} req_t;

    int         pass_cnt = 0;
    int         total_cnt = 0;
    int         cyc = 0;
    int         hs_cyc = 0;
    int         pop_cnt = 0;
    int         rsp_idx = 0;
    int         corrupt_burst = -1;
    int         corrupt_byte = 0;
    int         early_pos = -1;
    bit         noanswer = 0;
    bit         toggle_rdy = 0;
    logic [8:0] exp_q[$];
    req_t       req_q[$];
    logic [7:0] mem [256];
    logic [7:0] hand [14] = '{8'hA0, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00,
                              8'h01, 8'h00, 8'hA5, 8'hA5, 8'h03, 8'h80, 8'hF2, 8'hD2};

    always @(posedge clock) cyc <= cyc + 1;

    function automatic logic [31:0] step(input logic [31:0] v);
        step = v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, got, want);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_hdr(input logic [7:0] cmd, input int b, input bit last);
        int a;
        a = b * 4 * BW;
        exp_q.push_back({1'b0, cmd});
        exp_q.push_back({1'b0, 8'(BW - 1)});
        exp_q.push_back({1'b0, 8'(a >> 24)});
        exp_q.push_back({1'b0, 8'(a >> 16)});
        exp_q.push_back({1'b0, 8'(a >> 8)});
        exp_q.push_back({last, 8'(a)});
    endtask

    // Expected request bytes: all write frames plus the first nrd read frames.
    task automatic push_run(input int nrd);
        logic [31:0] lf;
        exp_q.delete();
        req_q.delete();
        rsp_idx = 0;
        pop_cnt = 0;
        lf = SEED;
        for (int b = 0; b < NB; b++) begin
            push_hdr(8'hA0, b, 1'b0);
            for (int w = 0; w < BW; w++) begin
                for (int j = 0; j < 4; j++)
                    exp_q.push_back({(w == BW - 1 && j == 3), lf[8*j +: 8]});
                lf = step(lf);
            end
        end
        for (int k = 0; k < 14; k++) exp_q[k] = {1'b0, hand[k]};
        for (int b = 0; b < nrd; b++) push_hdr(8'h80, b, 1'b1);
    endtask

    task automatic start_run();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("busy_after_start", 32'(busy_o), 32'd1);
        chk("done_clear_on_start", 32'(done_o), 32'd0);
    endtask

    task automatic wait_done(output int dcyc);
        int k;
        k = 0;
        while (!done_o && k < 3000) begin
            tick();
            k++;
        end
        dcyc = cyc;
        chk("done_reached", 32'(done_o), 32'd1);
    endtask

    initial begin
        m_tready = 1'b1;
        forever begin
            tick();
            m_tready = toggle_rdy ? ~m_tready : 1'b1;
        end
    end

    // Request-side monitor: scoreboard compare, stall stability, and loopback memory parser.
    initial begin
        bit         hold_v;
        logic [8:0] hold;
        logic [8:0] e;
        int         pidx, paddr;
        logic [7:0] pcmd, plen;
        hold_v = 0; hold = '0; pidx = 0; paddr = 0; pcmd = '0; plen = '0;
        forever begin
            @(negedge clock);
            if (reset) begin
                hold_v = 0;
                pidx = 0;
            end else begin
                if (hold_v) begin
                    chk("stall_hold", 32'({m_tvalid, m_tlast, m_tdata}), 32'({1'b1, hold}));
                    hold_v = 0;
                end
                if (m_tvalid && !m_tready) begin
                    hold_v = 1;
                    hold = {m_tlast, m_tdata};
                end
                if (m_tvalid && m_tready) begin
                    hs_cyc = cyc + 1;
                    pop_cnt++;
                    if (exp_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL m_byte_extra: got 0x%0h, no byte expected", m_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_byte", 32'({m_tkeep, m_tlast, m_tdata}), 32'({1'b1, e}));
                    end
                    case (pidx)
                        0: pcmd = m_tdata;
                        1: plen = m_tdata;
                        2, 3, 4, 5: paddr = (pidx == 2) ? int'(m_tdata) : ((paddr << 8) | int'(m_tdata));
                        default: if (pcmd == 8'hA0) mem[(paddr + pidx - 6) & 255] = m_tdata;
                    endcase
                    if (m_tlast) begin
                        if (pcmd == 8'h80) req_q.push_back('{addr: paddr, n: (int'(plen) + 1) * 4});
                        pidx = 0;
                    end else begin
                        pidx++;
                    end
                end
            end
        end
    end

    // Response side: replays memory contents, with optional corruption, early tlast or silence.
    initial begin
        req_t r;
        bit   live;
        int   cur;
        s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0; s_tkeep = 1'b0;
        forever begin
            @(negedge clock);
            if (noanswer) begin
                req_q.delete();
            end else if (req_q.size() > 0) begin
                r = req_q.pop_front();
                cur = rsp_idx;
                rsp_idx++;
                live = 1;
                for (int i = 0; i < r.n && live; i++) begin
                    s_tdata = mem[(r.addr + i) & 255];
                    if (cur == corrupt_burst && i == corrupt_byte) s_tdata = s_tdata ^ 8'hFF;
                    s_tlast = (cur == 0 && early_pos >= 0) ? (i == early_pos) : (i == r.n - 1);
                    s_tkeep = 1'b1;
                    s_tvalid = 1'b1;
                    while (live && !s_tready) begin
                        if (!busy_o || reset) live = 0;
                        else @(negedge clock);
                    end
                    if (live) begin
                        tick();
                        if (cur == 0 && i == early_pos) begin
                            chk("early_tlast_done", 32'(done_o), 32'd1);
                            chk("early_tlast_fault", 32'(fault_o), 32'd1);
                        end
                        @(negedge clock);
                    end
                end
                s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no summary, want run to finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          dc, k;
        logic [31:0] w6;
        reset = 1'b1;
        start_i = 1'b0;
        repeat (3) tick();
        chk("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("rst_m_tlast", 32'(m_tlast), 32'd0);
        chk("rst_m_tkeep", 32'(m_tkeep), 32'd0);
        chk("rst_m_tdata", 32'(m_tdata), 32'd0);
        chk("rst_s_tready", 32'(s_tready), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_pass", 32'(pass_o), 32'd0);
        chk("rst_fault", 32'(fault_o), 32'd0);
        chk("rst_err", 32'(err_count_o), 32'd0);
        reset = 1'b0;
        tick();

        // Clean run, m_tready held high.
        push_run(NB);
        start_run();
        wait_done(dc);
        chk("t1_pass", 32'(pass_o), 32'd1);
        chk("t1_fault", 32'(fault_o), 32'd0);
        chk("t1_err", 32'(err_count_o), 32'd0);
        chk("t1_bytes_left", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();

        // m_tready toggling every cycle, plus a start pulse while busy that must be ignored.
        toggle_rdy = 1;
        push_run(NB);
        start_run();
        repeat (20) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wait_done(dc);
        toggle_rdy = 0;
        chk("t2_pass", 32'(pass_o), 32'd1);
        chk("t2_err", 32'(err_count_o), 32'd0);
        chk("t2_bytes_left", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();

        // One corrupted byte: read burst 1, word 2, byte 0.
        corrupt_burst = 1;
        corrupt_byte = 8;
        push_run(NB);
        start_run();
        wait_done(dc);
        corrupt_burst = -1;
        chk("t3_err", 32'(err_count_o), 32'd1);
        chk("t3_pass", 32'(pass_o), 32'd0);
        chk("t3_fault", 32'(fault_o), 32'd0);
`ifdef TRAFFIC_GEN_CAPTURE_EN
        w6 = SEED;
        for (int i = 0; i < 6; i++) w6 = step(w6);
        chk("t3_fail_addr", 32'(fail_addr_o), 32'h18);
        chk("t3_fail_exp", fail_exp_o, w6);
        chk("t3_fail_got", fail_got_o, w6 ^ 32'h0000_00FF);
`else
        w6 = '0;
`endif
        repeat (3) tick();

        // s_tlast on byte 10 of 16 in the first read response.
        early_pos = 9;
        push_run(1);
        start_run();
`ifdef TRAFFIC_GEN_CAPTURE_EN
        chk("t4_capture_cleared", 32'(fail_addr_o), 32'd0);
`endif
        wait_done(dc);
        chk("t4_fault", 32'(fault_o), 32'd1);
        chk("t4_pass", 32'(pass_o), 32'd0);
        chk("t4_bytes_left", 32'(exp_q.size()), 32'd0);
        repeat (5) tick();
        early_pos = -1;

        // Silent responder: DONE exactly TIMEOUT cycles after the final request handshake.
        noanswer = 1;
        push_run(1);
        start_run();
        wait_done(dc);
        noanswer = 0;
        chk("t5_timeout_cycles", 32'(dc - hs_cyc), 32'(TO));
        chk("t5_fault", 32'(fault_o), 32'd1);
        chk("t5_pass", 32'(pass_o), 32'd0);
        chk("t5_bytes_left", 32'(exp_q.size()), 32'd0);
        repeat (3) tick();

        // Reset during WR_DAT, then a full replay from the seed.
        push_run(NB);
        start_run();
        k = 0;
        while (pop_cnt < 10 && k < 500) begin
            tick();
            k++;
        end
        chk("t6_reached_wr_dat", 32'(pop_cnt >= 10), 32'd1);
        reset = 1'b1;
        tick();
        chk("t6_rst_m_tvalid", 32'(m_tvalid), 32'd0);
        chk("t6_rst_busy", 32'(busy_o), 32'd0);
        chk("t6_rst_m_tlast", 32'(m_tlast), 32'd0);
        reset = 1'b0;
        tick();
        push_run(NB);
        start_run();
        wait_done(dc);
        chk("t6_pass", 32'(pass_o), 32'd1);
        chk("t6_err", 32'(err_count_o), 32'd0);
        chk("t6_bytes_left", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
